// File: rtl/systolic_feeder.sv
// Input-side driver for an N x N systolic MAC array: buffers A/B operands from a
// valid/ready stream, clears the accumulators, then feeds skewed zero-padded edges.
module systolic_feeder #(
  parameter int N     = 4,
  parameter int DW    = 32,
  parameter int K_MAX = 16,
  parameter int KW    = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [KW-1:0]   k_len,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] in_a,
  input  logic [N*DW-1:0] in_b,
  output logic            acc_clear,
  output logic [N*DW-1:0] a_edge,
  output logic [N*DW-1:0] b_edge,
  output logic            edge_valid,
  output logic            busy,
  output logic            done
);

  localparam int AW = (K_MAX > 1) ? $clog2(K_MAX) : 1;
  localparam int TW = $clog2(K_MAX + 2 * N);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_CLEAR  = 3'd2,
    S_STREAM = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [KW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [TW-1:0]     t_q, t_d;
  logic [TW-1:0]     last_s;
  logic [TW-1:0]     tn_s;
  logic              we_s;
  logic              in_ready_q, acc_clear_q, edge_valid_q, busy_q, done_q;
  logic [N*DW-1:0]   a_edge_q, a_edge_d;
  logic [N*DW-1:0]   b_edge_q, b_edge_d;

  // a_buf_q[k][i] holds A[i][k]; b_buf_q[k][j] holds B[k][j]
  logic [DW-1:0]     a_buf_q [K_MAX][N];
  logic [DW-1:0]     b_buf_q [K_MAX][N];

  assign last_s = TW'(k_q) + TW'(2 * N - 3);

  // Next-state, counter and buffer write-enable logic
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    wr_ptr_d = wr_ptr_q;
    t_d      = t_q;
    we_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && (k_len != '0) && (k_len <= KW'(K_MAX))) begin
          state_d  = S_LOAD;
          k_d      = k_len;
          wr_ptr_d = '0;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          we_s     = 1'b1;
          wr_ptr_d = wr_ptr_q + KW'(1);
          if (wr_ptr_q == (k_q - KW'(1))) begin
            state_d = S_CLEAR;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_CLEAR: begin
        state_d = S_STREAM;
        t_d     = '0;
      end
      S_STREAM: begin
        if (t_q == last_s) begin
          state_d = S_DRAIN;
        end else begin
          t_d     = t_q + TW'(1);
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Edge values for the upcoming stream step; registered so they line up with t
  always_comb begin
    a_edge_d = '0;
    b_edge_d = '0;
    if (state_q == S_CLEAR) begin
      tn_s = '0;
    end else begin
      tn_s = t_q + TW'(1);
    end
    if (state_d == S_STREAM) begin
      for (int i = 0; i < N; i++) begin
        if ((tn_s >= TW'(i)) && ((tn_s - TW'(i)) < TW'(k_q))) begin
          a_edge_d[i*DW +: DW] = a_buf_q[AW'(tn_s - TW'(i))][i];
          b_edge_d[i*DW +: DW] = b_buf_q[AW'(tn_s - TW'(i))][i];
        end else begin
          a_edge_d[i*DW +: DW] = '0;
          b_edge_d[i*DW +: DW] = '0;
        end
      end
    end else begin
      a_edge_d = '0;
      b_edge_d = '0;
    end
  end

  // Operand buffers: contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (we_s) begin
      for (int i = 0; i < N; i++) begin
        a_buf_q[AW'(wr_ptr_q)][i] <= in_a[i*DW +: DW];
        b_buf_q[AW'(wr_ptr_q)][i] <= in_b[i*DW +: DW];
      end
    end
  end

  // State, counters and registered outputs decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      wr_ptr_q     <= '0;
      t_q          <= '0;
      in_ready_q   <= 1'b0;
      acc_clear_q  <= 1'b0;
      edge_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      a_edge_q     <= '0;
      b_edge_q     <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      wr_ptr_q     <= wr_ptr_d;
      t_q          <= t_d;
      in_ready_q   <= (state_d == S_LOAD);
      acc_clear_q  <= (state_d == S_CLEAR);
      edge_valid_q <= (state_d == S_STREAM);
      busy_q       <= (state_d != S_IDLE);
      done_q       <= (state_d == S_DONE);
      a_edge_q     <= a_edge_d;
      b_edge_q     <= b_edge_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign acc_clear  = acc_clear_q;
  assign edge_valid = edge_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign a_edge     = a_edge_q;
  assign b_edge     = b_edge_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: directed and randomized jobs compared
// against a matrix-level model and a behavioural systolic accumulation of the edges.
module tb_systolic_feeder;
  localparam int N = 4, DW = 32, K_MAX = 16, KW = 5;

  logic            clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic [KW-1:0]   k_len = '0;
  logic [N*DW-1:0] in_a = '0, in_b = '0;
  logic            in_ready, acc_clear, edge_valid, busy, done;
  logic [N*DW-1:0] a_edge, b_edge;

  systolic_feeder #(.N(N), .DW(DW), .K_MAX(K_MAX), .KW(KW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .acc_clear(acc_clear), .a_edge(a_edge), .b_edge(b_edge),
    .edge_valid(edge_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [DW-1:0] am [N][K_MAX];
  logic [DW-1:0] bm [K_MAX][N];
  logic [DW-1:0] arec [64][N];
  logic [DW-1:0] brec [64][N];
  logic [DW-1:0] c_sys [N][N];

  task automatic chk(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] exp_a(input int t, input int k);
    logic [N*DW-1:0] v = '0;
    for (int i = 0; i < N; i++)
      if (t - i >= 0 && t - i < k) v[i*DW +: DW] = am[i][t-i];
    return v;
  endfunction

  function automatic logic [N*DW-1:0] exp_b(input int t, input int k);
    logic [N*DW-1:0] v = '0;
    for (int j = 0; j < N; j++)
      if (t - j >= 0 && t - j < k) v[j*DW +: DW] = bm[t-j][j];
    return v;
  endfunction

  function automatic logic [N*DW-1:0] rnd_vec();
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = $urandom;
    return v;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K_MAX; k++) begin
        am[i][k] = '0;
        bm[k][i] = '0;
      end
  endtask

  task automatic fill_rand(input int k_n);
    clear_model();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < k_n; k++) begin
        am[i][k] = $urandom;
        bm[k][i] = $urandom;
      end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1'b0);
    chk({tag, "_acc_clear"}, acc_clear, 1'b0);
    chk({tag, "_edge_valid"}, edge_valid, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_a_edge"}, a_edge, '0);
    chk({tag, "_b_edge"}, b_edge, '0);
  endtask

  // gap_mode: 0 none, 1 random idle beats, 2 two idle beats before beat 1
  task automatic run_job(input int k_n, input int gap_mode, input int abort_at);
    int cnt, t, len;
    logic [DW-1:0] s, r;
    len = k_n + 2 * N - 2;
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    start = 1'b1;
    k_len = KW'(k_n);
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < k_n; k++) begin
      int gap;
      gap = (gap_mode == 1) ? int'($urandom_range(0, 2)) : ((gap_mode == 2 && k == 1) ? 2 : 0);
      repeat (gap) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_a = rnd_vec();
        in_b = rnd_vec();
      end
      @(negedge clk);
      chk("load_ready", in_ready, 1'b1);
      chk("load_busy", busy, 1'b1);
      in_valid = 1'b1;
      for (int i = 0; i < N; i++) begin
        in_a[i*DW +: DW] = am[i][k];
        in_b[i*DW +: DW] = bm[k][i];
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    cnt = 0;
    while (cnt < k_n + 2 * N + 1) begin
      @(negedge clk);
      cnt++;
      if (cnt == abort_at) begin
        #2 rst_n = 1'b0;
        #1 chk_outputs_zero("async_rst");
        in_valid = 1'b0;
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_outputs_zero("post_rst");
        return;
      end
      t = cnt - 2;
      chk("acc_clear", acc_clear, cnt == 1);
      chk("edge_valid", edge_valid, (t >= 0 && t < len));
      chk("a_edge", a_edge, exp_a(t, k_n));
      chk("b_edge", b_edge, exp_b(t, k_n));
      chk("done", done, cnt == k_n + 2 * N + 1);
      chk("no_ready", in_ready, 1'b0);
      if (t >= 0 && t < len)
        for (int i = 0; i < N; i++) begin
          arec[t][i] = a_edge[i*DW +: DW];
          brec[t][i] = b_edge[i*DW +: DW];
        end
      in_valid = 1'($urandom_range(0, 1));
      in_a = rnd_vec();
      in_b = rnd_vec();
      if (cnt == 3) begin
        start = 1'b1;
        k_len = KW'(3);
      end else begin
        start = 1'b0;
      end
    end
    in_valid = 1'b0;
    start = 1'b0;
    // PE(i,j) sees a from row i delayed j cycles and b from column j delayed i cycles
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = '0;
        r = '0;
        for (int t1 = 0; t1 < len; t1++)
          if (t1 + j - i >= 0 && t1 + j - i < len)
            s = s + arec[t1][i] * brec[t1+j-i][j];
        for (int k = 0; k < k_n; k++) r = r + am[i][k] * bm[k][j];
        c_sys[i][j] = s;
        chk("c_matrix", s, r);
      end
  endtask

  task automatic bad_start(input int kv);
    @(negedge clk);
    start = 1'b1;
    k_len = KW'(kv);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bad_k_busy", busy, 1'b0);
      chk("bad_k_clear", acc_clear, 1'b0);
      chk("bad_k_ready", in_ready, 1'b0);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;

    clear_model();
    am[0][0] = 32'd1; am[0][1] = 32'd2; am[1][0] = 32'd3; am[1][1] = 32'd4;
    bm[0][0] = 32'd5; bm[0][1] = 32'd6; bm[1][0] = 32'd7; bm[1][1] = 32'd8;
    run_job(2, 0, 0);
    chk("c00", c_sys[0][0], 32'd19);
    chk("c01", c_sys[0][1], 32'd22);
    chk("c10", c_sys[1][0], 32'd43);
    chk("c11", c_sys[1][1], 32'd50);
    run_job(2, 2, 0);
    chk("gap_c11", c_sys[1][1], 32'd50);

    bad_start(0);
    bad_start(17);

    clear_model();
    for (int i = 0; i < N; i++) begin
      am[i][0] = 32'(i + 1);
      bm[0][i] = 32'd1;
    end
    run_job(1, 0, 0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) chk("k1_c", c_sys[i][j], 32'(i + 1));

    for (int n = 0; n < 6; n++) begin
      int kr;
      kr = int'($urandom_range(1, K_MAX));
      fill_rand(kr);
      run_job(kr, 1, 0);
    end
    fill_rand(K_MAX);
    run_job(K_MAX, 0, 0);

    fill_rand(8);
    run_job(8, 0, 5);
    fill_rand(3);
    run_job(3, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
Input-side driver for an N×N array of systolic MAC units.
- Loads an A operand (N×K) and a B operand (K×N) over a valid/ready stream into internal buffers.
- Pulses an accumulator clear, then drives skewed, zero-padded edge streams into the array's west (a) and north (b) edges.
- Signals done once every processing element holds its final C[i][j].
- Sits between the host/DMA stream and the array; the controller reads c_out after done.

Parameters:
- N, 4: array dimension (rows = columns).
- DW, 32: operand width per element.
- K_MAX, 16: maximum inner dimension (buffer depth).
- KW, 5: width of k_len, equal to clog2(K_MAX+1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a job; sampled only in IDLE.
- k_len  in  KW  inner dimension K for the job; latched with start.
- in_valid  in  1  load beat valid.
- in_ready  out  1  load beat accepted when in_valid and in_ready are both 1.
- in_a  in  N*DW  column k of A; element i at bits [i*DW +: DW].
- in_b  in  N*DW  row k of B; element j at bits [j*DW +: DW].
- acc_clear  out  1  one-cycle clear pulse to all PE accumulators.
- a_edge  out  N*DW  west-edge operand into row i, slice i.
- b_edge  out  N*DW  north-edge operand into column j, slice j.
- edge_valid  out  1  high during stream cycles.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse: array results are final.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - All outputs 0: in_ready, acc_clear, a_edge, b_edge, edge_valid, busy, done.
  - Counters 0. Buffer contents are don't-care.
  - Reset mid-job abandons the job without completing it.
- State machine:
  - IDLE:
    - start=1 and 1<=k_len<=K_MAX: latch K=k_len, go to LOAD.
    - start with k_len=0 or k_len>K_MAX: ignored, stay in IDLE.
  - LOAD:
    - in_ready=1.
    - Each handshake writes in_a/in_b into slot wr_ptr, then wr_ptr+1.
    - After beat K-1 is accepted: next state CLEAR. in_ready is 0 from that cycle on.
  - CLEAR: acc_clear=1 for exactly one cycle, then go to STREAM with t=0.
  - STREAM:
    - Lasts K+2N-2 cycles (t=0..K+2N-3), edge_valid=1.
    - Edge outputs are registers; the values for cycle t are visible while t is current.
    - a_edge slice i = A[i][t-i] if 0<=t-i<K, else 0.
    - b_edge slice j = B[t-j][j] if 0<=t-j<K, else 0.
  - DRAIN:
    - One cycle, edge_valid=0, edges 0.
    - Covers the PE register stage so the last accumulation in PE(N-1,N-1) has landed.
  - DONE: done=1 for one cycle, then IDLE.
- Outside STREAM, a_edge and b_edge are 0. Zero operands leave accumulators unchanged.
- Ignored inputs:
  - start while busy=1.
  - in_valid outside LOAD; no data is written.
- Back-to-back jobs: start is accepted in the cycle after the done pulse (state is IDLE).
- Arithmetic: the block only moves data; operands pass unmodified, with no width change.
- Latency from the last load beat to done is exactly K+2N+1 cycles: CLEAR 1 + STREAM K+2N-2 + DRAIN 1 + DONE 1.

Test Plan:
- Reset: rst_n=0 asserted mid-STREAM, asynchronously between clock edges.
  -> All outputs 0 immediately.
  -> After release, state is IDLE and busy=0.
- N=2, K=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]]. Load beats ({in_a}/{in_b}, slice0 first): (1,3)/(5,6), then (2,4)/(7,8).
  -> a_edge per t: (1,0), (2,3), (0,4), (0,0).
  -> b_edge per t: (5,0), (7,6), (0,8), (0,0).
  -> done is 7 cycles after beat 2.
  -> Attached 2×2 array reads C=[[19,22],[43,50]].
- LOAD with in_valid toggling 1,0,0,1: only 2 writes occur; state moves to CLEAR after the 2nd handshake; stream matches the previous case.
- k_len=0, and k_len=17 with K_MAX=16, each with start=1 -> busy stays 0, no acc_clear.
- K=1, N=4, A column=(1,2,3,4), B row=(1,1,1,1):
  -> 7 stream cycles.
  -> Row i receives nonzero only at t=i.
  -> All PEs read C[i][j]=i+1.
- start pulsed during STREAM -> ignored. A second job started right after done runs with a fresh acc_clear; no carry-over of sums.
